// File: rtl/reg_seq_pkg.sv
// Shared definitions for the register-unit command sequencer: widths, program entry layout,
// control codes and sequencer state encoding.
package reg_seq_pkg;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;
  localparam int DW     = 4;
  localparam int CW     = 3;
  localparam int EW     = 12;

  localparam int DATA_LSB = 0;
  localparam int CTRL_LSB = 4;
  localparam int EXP_LSB  = 7;
  localparam int CHK_BIT  = 11;

  localparam logic [CW-1:0] CTRL_NOP = 3'o0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } seq_state_e;

  typedef struct packed {
    logic          chk_en;
    logic [DW-1:0] expected;
    logic [CW-1:0] control;
    logic [DW-1:0] data;
  } entry_t;

  function automatic entry_t unpack_entry(input logic [EW-1:0] raw);
    entry_t e;
    e.data     = raw[DATA_LSB +: DW];
    e.control  = raw[CTRL_LSB +: CW];
    e.expected = raw[EXP_LSB +: DW];
    e.chk_en   = raw[CHK_BIT];
    return e;
  endfunction

  // Requests longer than the program are clamped so the entry index never wraps.
  function automatic logic [ADDR_W:0] clamp_len(input logic [ADDR_W:0] req);
    logic [ADDR_W:0] lim;
    lim = (ADDR_W+1)'(DEPTH);
    if (req > lim) begin
      return lim;
    end else begin
      return req;
    end
  endfunction

endpackage

// File: rtl/reg_seq_checker.sv
// Invariant checks for the sequencer outputs, kept apart from the datapath.
module reg_seq_checker
  import reg_seq_pkg::*;
(
  input logic          clk,
  input logic          rst_n,
  input logic          busy,
  input logic          done,
  input logic          err,
  input logic [DW-1:0] cmd_data,
  input logic [CW-1:0] cmd_control,
  input logic [3:0]    err_count
);

  a_nop_when_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    !busy |-> (cmd_data == {DW{1'b0}} && cmd_control == CTRL_NOP));

  a_done_not_busy: assert property (@(posedge clk) disable iff (!rst_n)
    done |-> !busy);

  a_done_single_cycle: assert property (@(posedge clk) disable iff (!rst_n)
    done |=> !done);

  a_count_implies_err: assert property (@(posedge clk) disable iff (!rst_n)
    (err_count != 4'd0) |-> err);

endmodule

// File: rtl/reg_seq_prog_mem.sv
// Program store for the sequencer: DEPTH x 12-bit entries, synchronous write, asynchronous read.
// Contents are intentionally not reset so a program survives a reset of the sequencer.
module reg_seq_prog_mem
  import reg_seq_pkg::*;
(
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [EW-1:0]     wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [EW-1:0]     rdata
);

  logic [EW-1:0] mem_r [DEPTH];

  // Entry write port
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  assign rdata = mem_r[raddr];

endmodule

// File: rtl/reg_cmd_sequencer.sv
// Replays stored (data, control) commands into the register unit one per clock and checks the
// unit's output one cycle later against each entry's expected value.
module reg_cmd_sequencer
  import reg_seq_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [EW-1:0]     prog_data,
  input  logic [ADDR_W:0]   run_len,
  input  logic              start,
  input  logic              abort,
  output logic [DW-1:0]     cmd_data,
  output logic [CW-1:0]     cmd_control,
  input  logic [DW-1:0]     unit_q,
  output logic              busy,
  output logic              done,
  output logic              err,
  output logic [3:0]        err_count,
  output logic [ADDR_W-1:0] first_err_addr
);

  seq_state_e        state_r, next_state_s;
  logic [ADDR_W-1:0] idx_r, rd_addr_s;
  logic [ADDR_W:0]   len_r, start_len_s;
  logic [EW-1:0]     rd_raw_s;
  entry_t            rd_entry_s, cur_r;

  logic              pipe_valid_r, pipe_chk_r;
  logic [DW-1:0]     pipe_exp_r;
  logic [ADDR_W-1:0] pipe_idx_r;

  logic              busy_r, done_r, err_r;
  logic [3:0]        err_count_r;
  logic [ADDR_W-1:0] first_err_r;
  logic              start_ok_s, last_s, mismatch_s, prog_we_s;

  assign prog_we_s = prog_we & ~busy_r;

  reg_seq_prog_mem u_mem (
    .clk   (clk),
    .we    (prog_we_s),
    .waddr (prog_addr),
    .wdata (prog_data),
    .raddr (rd_addr_s),
    .rdata (rd_raw_s)
  );

  // Read address, entry decode, last-entry and mismatch detection
  always_comb begin
    start_ok_s  = start & ~abort;
    start_len_s = clamp_len(run_len);
    last_s      = (({1'b0, idx_r} + (ADDR_W+1)'(1'b1)) == len_r);
    rd_entry_s  = unpack_entry(rd_raw_s);
    // The check of the entry in flight is dropped when the run is aborted.
    mismatch_s  = pipe_valid_r & pipe_chk_r & (unit_q != pipe_exp_r) & ~abort;
    if (state_r == ISSUE) begin
      rd_addr_s = idx_r + ADDR_W'(1'b1);
    end else begin
      rd_addr_s = {ADDR_W{1'b0}};
    end
  end

  // Next-state logic
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_ok_s) begin
          if (start_len_s == {(ADDR_W+1){1'b0}}) begin
            next_state_s = DRAIN;
          end else begin
            next_state_s = ISSUE;
          end
        end else begin
          next_state_s = IDLE;
        end
      end
      ISSUE: begin
        if (abort) begin
          next_state_s = IDLE;
        end else if (last_s) begin
          next_state_s = DRAIN;
        end else begin
          next_state_s = ISSUE;
        end
      end
      DRAIN: begin
        if (abort) begin
          next_state_s = IDLE;
        end else begin
          next_state_s = DONE;
        end
      end
      DONE:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // State register, issue register and one-deep check pipeline
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      busy_r       <= 1'b0;
      done_r       <= 1'b0;
      idx_r        <= {ADDR_W{1'b0}};
      len_r        <= {(ADDR_W+1){1'b0}};
      cur_r        <= entry_t'({EW{1'b0}});
      pipe_valid_r <= 1'b0;
      pipe_chk_r   <= 1'b0;
      pipe_exp_r   <= {DW{1'b0}};
      pipe_idx_r   <= {ADDR_W{1'b0}};
    end else begin
      state_r <= next_state_s;
      busy_r  <= (next_state_s == ISSUE) || (next_state_s == DRAIN);
      done_r  <= (state_r == DRAIN) && (next_state_s == DONE);
      if (next_state_s == ISSUE) begin
        cur_r <= rd_entry_s;
        idx_r <= (state_r == ISSUE) ? idx_r + ADDR_W'(1'b1) : {ADDR_W{1'b0}};
      end else begin
        cur_r <= entry_t'({EW{1'b0}});
        idx_r <= idx_r;
      end
      if ((state_r == IDLE) && start_ok_s) begin
        len_r <= start_len_s;
      end else begin
        len_r <= len_r;
      end
      // The entry on cmd_* this cycle is checked against unit_q next cycle.
      pipe_valid_r <= (state_r == ISSUE) && !abort;
      pipe_chk_r   <= cur_r.chk_en;
      pipe_exp_r   <= cur_r.expected;
      pipe_idx_r   <= idx_r;
    end
  end

  // Sticky error flag, saturating mismatch count and first failing entry
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_r       <= 1'b0;
      err_count_r <= 4'd0;
      first_err_r <= {ADDR_W{1'b0}};
    end else if ((state_r == IDLE) && start_ok_s) begin
      err_r       <= 1'b0;
      err_count_r <= 4'd0;
      first_err_r <= {ADDR_W{1'b0}};
    end else if (mismatch_s) begin
      err_r <= 1'b1;
      if (err_count_r != 4'hF) begin
        err_count_r <= err_count_r + 4'd1;
      end
      if (!err_r) begin
        first_err_r <= pipe_idx_r;
      end
    end
  end

  assign cmd_data       = cur_r.data;
  assign cmd_control    = cur_r.control;
  assign busy           = busy_r;
  assign done           = done_r;
  assign err            = err_r;
  assign err_count      = err_count_r;
  assign first_err_addr = first_err_r;

  reg_seq_checker u_chk (
    .clk         (clk),
    .rst_n       (rst_n),
    .busy        (busy_r),
    .done        (done_r),
    .err         (err_r),
    .cmd_data    (cur_r.data),
    .cmd_control (cur_r.control),
    .err_count   (err_count_r)
  );

endmodule
